// File: rtl/mem_rr_arbiter.sv
// Shared single-port data memory behind a round-robin arbiter: one transfer per
// cycle, registered per-port read response, and an error pulse for out-of-range accesses.
module mem_rr_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int MEM_DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_wr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            err
);

  localparam int PIDX_W = $clog2(NUM_PORTS);
  localparam int MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [PIDX_W-1:0]     last_grant_q, last_grant_d;
  logic [NUM_PORTS-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  logic                  gnt_found;
  logic [PIDX_W-1:0]     gnt_idx;
  logic                  acc;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [MIDX_W-1:0]     midx;
  logic                  in_range;

  // Rotating priority search starting just after the last accepted port.
  always_comb begin
    int cand;
    cand      = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_PORTS;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = PIDX_W'(cand);
      end
    end
  end

  always_comb begin
    acc       = gnt_found && !rst;
    req_ready = '0;
    if (acc) req_ready[gnt_idx] = 1'b1;
    sel_wr    = req_wr[gnt_idx];
    sel_addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    midx      = sel_addr[MIDX_W-1:0];
    in_range  = ({1'b0, sel_addr} < DEPTH_C);
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    err_d        = 1'b0;
    mem_d        = mem_q;
    if (acc) begin
      last_grant_d = gnt_idx;
      err_d        = !in_range;
      if (sel_wr) begin
        if (in_range) mem_d[midx] = sel_wdata;
      end else begin
        rsp_valid_d[gnt_idx] = 1'b1;
        rsp_rdata_d          = in_range ? mem_q[midx] : '0;
      end
    end
  end

  // Reset clears the stored words too, so the memory restarts from all zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= PIDX_W'(NUM_PORTS - 1);
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      err_q        <= 1'b0;
      mem_q        <= '{default: '0};
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      err_q        <= err_d;
      mem_q        <= mem_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed and randomized bench for mem_rr_arbiter against a rule-level
// reference model (rotating priority pointer plus a plain word array).
module tb_mem_rr_arbiter;

  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 6;

  logic             clk;
  logic             rst;
  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_ready;
  logic [NP-1:0]    req_wr;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             err;

  mem_rr_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            ptr;
  logic [DW-1:0] mem_m [8];
  logic [NP-1:0] e_rv;
  logic [DW-1:0] e_rd;
  logic          e_err;
  int            last_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check the grant, clock, advance the model, check responses.
  task automatic step(input logic r);
    int g;
    int p;
    logic [AW-1:0] a;
    rst = r;
    #1;
    g = -1;
    if (!r) begin
      for (int k = 1; k <= NP; k++) begin
        p = (ptr + k) % NP;
        if (g < 0 && req_valid[p]) g = p;
      end
    end
    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    last_g = g;
    @(posedge clk);
    #1;
    if (r) begin
      ptr = NP - 1;
      for (int i = 0; i < 8; i++) mem_m[i] = '0;
      e_rv = '0; e_rd = '0; e_err = 1'b0;
    end else begin
      e_rv  = '0;
      e_err = 1'b0;
      if (g >= 0) begin
        ptr   = g;
        a     = req_addr[g*AW +: AW];
        e_err = (int'(a) >= DEPTH);
        if (req_wr[g]) begin
          if (int'(a) < DEPTH) mem_m[a] = req_wdata[g*DW +: DW];
        end else begin
          e_rv[g] = 1'b1;
          e_rd    = (int'(a) < DEPTH) ? mem_m[a] : '0;
        end
      end
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
    chk("err", 32'(err), 32'(e_err));
  endtask

  task automatic set_port(input int p, input logic v, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[p]         = v;
    req_wr[p]            = wr;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*DW +: DW] = d;
  endtask

  task automatic only_port(input int p, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = '0;
    set_port(p, 1'b1, wr, a, d);
  endtask

  logic pend [NP];
  int   waitc [NP];
  logic rv;

  initial begin
    ptr = NP - 1;
    for (int i = 0; i < 8; i++) mem_m[i] = '0;
    e_rv = '0; e_rd = '0; e_err = 1'b0; last_g = -1;
    rst = 1'b1; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    @(posedge clk); #1;

    // Reset and idle
    step(1'b1); step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);

    // Single port write then read
    only_port(0, 1'b1, 3'd3, 8'hA5); step(1'b0);
    only_port(0, 1'b0, 3'd3, 8'h00); step(1'b0);
    chk("single_rd_data", 32'(rsp_rdata), 32'hA5);
    chk("single_rd_valid", 32'(rsp_valid), 32'h1);

    // Preload from port 3 so port 0 is next in line, then all ports read
    for (int i = 0; i < NP; i++) begin
      only_port(3, 1'b1, AW'(i), DW'(8'h10 + i)); step(1'b0);
    end
    for (int i = 0; i < NP; i++) set_port(i, 1'b1, 1'b0, AW'(i), 8'h00);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_order", 32'(req_ready), 32'd1 << (k % NP));
      step(1'b0);
      chk("rr_data", 32'(rsp_rdata), 32'h10 + 32'(k % NP));
    end

    // Contention across an idle gap: pointer must be held
    req_valid = '0;
    set_port(1, 1'b1, 1'b0, 3'd1, 8'h00);
    set_port(2, 1'b1, 1'b0, 3'd2, 8'h00);
    #1; chk("contend_first", 32'(req_ready), 32'h2);
    step(1'b0);
    req_valid = '0;
    for (int i = 0; i < 3; i++) step(1'b0);
    req_valid[1] = 1'b1; req_valid[2] = 1'b1;
    #1; chk("contend_after_gap", 32'(req_ready), 32'h4);
    step(1'b0);

    // Out-of-range write and read, then sweep the implemented words
    only_port(0, 1'b1, 3'd7, 8'hFF); step(1'b0);
    chk("oor_wr_err", 32'(err), 32'h1);
    only_port(0, 1'b0, 3'd7, 8'h00); step(1'b0);
    chk("oor_rd_err", 32'(err), 32'h1);
    chk("oor_rd_data", 32'(rsp_rdata), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      only_port(1, 1'b0, AW'(i), 8'h00); step(1'b0);
    end

    // Reset in the cycle a read is presented
    only_port(0, 1'b1, 3'd2, 8'h5A); step(1'b0);
    only_port(0, 1'b0, 3'd2, 8'h00); step(1'b1);
    chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
    step(1'b0);
    chk("rst_mem_cleared", 32'(rsp_rdata), 32'h0);
    chk("rst_rd_valid", 32'(rsp_valid), 32'h1);

    // Randomized traffic with fairness tracking
    req_valid = '0;
    for (int p = 0; p < NP; p++) begin pend[p] = 1'b0; waitc[p] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] && ($urandom_range(0, 2) != 0)) begin
          pend[p] = 1'b1;
          waitc[p] = 0;
          set_port(p, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
        end
        req_valid[p] = pend[p];
      end
      rv = ($urandom_range(0, 99) == 0);
      step(rv);
      for (int p = 0; p < NP; p++) begin
        if (rv) waitc[p] = 0;
        else if (pend[p]) begin
          waitc[p]++;
          if (p == last_g) begin
            chk("fairness", 32'(waitc[p] <= NP), 32'h1);
            pend[p] = 1'b0;
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Parametrised shared data-memory subsystem: NUM_PORTS requesters (CPU cores, DMA, debug) reach one internal single-port memory through a round-robin arbiter. It replaces the point-to-point CPU/data-memory wiring with a valid/ready request channel per port and a registered per-port read response. It sits between the CPU cluster and the data storage in the top level.

## Interface
- NUM_PORTS, 2: number of requester ports (>= 2).
- DATA_WIDTH, 8: memory word width.
- ADDR_WIDTH, 3: request address width.
- MEM_DEPTH, 8: number of implemented words, <= 2**ADDR_WIDTH.

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_PORTS  per-port request present.
- req_ready  out  NUM_PORTS  per-port grant; transfer when valid & ready.
- req_wr  in  NUM_PORTS  1 = write, 0 = read.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data, port i at [i*DATA_WIDTH +: DATA_WIDTH].
- rsp_valid  out  NUM_PORTS  one-cycle pulse, read data for port i on rsp_rdata.
- rsp_rdata  out  DATA_WIDTH  shared read data bus.
- err  out  1  one-cycle pulse: accepted request had address >= MEM_DEPTH.

## Operation
- Storage: MEM_DEPTH x DATA_WIDTH array, zeroed by rst.
- Arbitration: combinational, one grant per cycle. Search starts at (last_grant+1) mod NUM_PORTS, wraps, grants first port with req_valid=1. req_ready is one-hot or zero and never asserted for a port with req_valid=0.
- last_grant register updates to granted index only on an accepted transfer; held when no request is present. Reset value NUM_PORTS-1, so port 0 has first priority after reset.
- Fairness: a port holding req_valid is granted within NUM_PORTS cycles.
- Write accepted: word at req_addr written with req_wdata at that edge. No response pulse.
- Read accepted: next cycle, rsp_valid[i]=1 and rsp_rdata = stored word; other rsp_valid bits 0.
- Out-of-range address (>= MEM_DEPTH): transfer still completes (ready asserted). A write is dropped. A read returns rsp_valid with rsp_rdata=0. err pulses in the cycle after acceptance.
- rsp_rdata holds its last value when rsp_valid is all zero.
- Requesters must keep req_addr, req_wr and req_wdata stable while req_valid=1 and req_ready=0.

## Timing
- Reset values: req_ready=0 (forced while rst=1), rsp_valid=0, rsp_rdata=0, err=0, last_grant=NUM_PORTS-1, memory all 0.
- Grant latency: 0 cycles. req_ready is valid in the same cycle as req_valid if the port wins.
- Read latency: accept at edge N; rsp_valid/rsp_rdata are valid in cycle N+1.
- Throughput: one transfer per cycle aggregate. Back-to-back reads from different ports give consecutive rsp pulses.
- Write then read of the same address on consecutive accepts: the read returns the new data.
- rst asserted mid-operation: a pending response is discarded. rsp_valid=0 the cycle after rst. Requests presented while rst=1 are not accepted.

## Test plan
- Reset/idle: hold rst 2 cycles, then no requests -> req_ready=0, rsp_valid=0, rsp_rdata=0, err=0 every cycle.
- Single port R/W: port 0 writes 0xA5 to addr 3, next cycle reads addr 3 -> rsp_valid=01 one cycle after read accept, rsp_rdata=0xA5.
- Round-robin, NUM_PORTS=4: all ports hold valid reads of addr i (preloaded 0x10+i) -> grant order 0,1,2,3,0; each rsp_rdata=0x10+i; every port granted within 4 cycles.
- Contention with idle gap: ports 1 and 2 valid, port 1 granted, then all requests drop for 3 cycles, then ports 1 and 2 re-request -> port 2 granted first (pointer held across the idle cycles).
- Out of range, MEM_DEPTH=6, ADDR_WIDTH=3: write 0xFF to addr 7, then read addr 7 -> both accepted, err pulses after each, read returns 0, addr 0..5 unchanged.
- Reset mid-read: assert rst in the cycle a read is accepted -> no rsp_valid pulse; after reset, a read of a previously written address returns 0.
